bus_demux4: RTL and testbench

Destination-side counterpart of the datapath source-select multiplexers: takes one 16-bit word stream with a 2-bit destination select and routes each word to one of four destination ports. Each destination has its own small first-word-fall-through FIFO and a valid/ready handshake, so a stalled destination never blocks words bound for other destinations once they are accepted. The block sits between the write-back bus and consumers such as the register file, memory write port, I/O port and debug capture.

---
 rtl/bus_demux4.sv | 146 ++++++++++++++
 tb/tb_bus_demux4.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bus_demux4.sv
`default_nettype none
// ==========================================================================
// bus_demux4 : routes one selected word stream into four FWFT FIFO ports
// Revision   : 1.0
// ==========================================================================
module bus_demux4 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [3:0]         full,
  output logic               overflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] C_COUNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] C_COUNT_ONE  = CW'(1);
  localparam logic [PW-1:0] C_PTR_ONE    = PW'(1);
  localparam logic [7:0]    C_STALL_MAX  = 8'd255;

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PARTIAL = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  logic [3:0] port_full;
  logic [3:0] port_valid;
  logic       stall;
  logic [7:0] stall_cnt_d;
  logic [7:0] stall_cnt_q;
  logic       overflow_err_d;
  logic       overflow_err_q;

  // Ready looks only at the addressed port's registered fill state.
  assign in_ready     = !port_full[in_sel];
  assign out_valid    = port_valid;
  assign full         = port_full;
  assign overflow_err = overflow_err_q;

  generate
    for (genvar i = 0; i < 4; i++) begin : g_port
      localparam logic [1:0] PORT_ID = 2'(i);

      logic [WIDTH-1:0] mem_q [DEPTH];
      logic [WIDTH-1:0] mem_d [DEPTH];
      logic [PW-1:0]    rd_ptr_q;
      logic [PW-1:0]    rd_ptr_d;
      logic [PW-1:0]    wr_ptr_q;
      logic [PW-1:0]    wr_ptr_d;
      logic [CW-1:0]    count_q;
      logic [CW-1:0]    count_d;
      logic [1:0]       state;
      logic             push;
      logic             pop;

      always_comb begin
        state = ST_PARTIAL;
        if (count_q == '0) begin
          state = ST_EMPTY;
        end else if (count_q == C_COUNT_FULL) begin
          state = ST_FULL;
        end
      end

      assign port_valid[i] = (state != ST_EMPTY);
      assign port_full[i]  = (state == ST_FULL);

      assign push = in_valid && in_ready && (in_sel == PORT_ID);
      assign pop  = port_valid[i] && out_ready[i];

      assign out_data[i*WIDTH +: WIDTH] = mem_q[rd_ptr_q];

      always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
          mem_d[wr_ptr_q] = in_data;
          wr_ptr_d        = wr_ptr_q + C_PTR_ONE;
        end
        if (pop) begin
          rd_ptr_d = rd_ptr_q + C_PTR_ONE;
        end
        case ({push, pop})
          2'b10:   count_d = count_q + C_COUNT_ONE;
          2'b01:   count_d = count_q - C_COUNT_ONE;
          default: count_d = count_q;
        endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < DEPTH; k++) begin
            mem_q[k] <= '0;
          end
          rd_ptr_q <= '0;
          wr_ptr_q <= '0;
          count_q  <= '0;
        end else begin
          mem_q    <= mem_d;
          rd_ptr_q <= rd_ptr_d;
          wr_ptr_q <= wr_ptr_d;
          count_q  <= count_d;
        end
      end
    end
  endgenerate

  // The error latches on the stall cycle that follows 255 consecutive stalls.
  assign stall = in_valid && !in_ready;

  always_comb begin
    stall_cnt_d    = 8'd0;
    overflow_err_d = overflow_err_q;
    if (stall) begin
      if (stall_cnt_q == C_STALL_MAX) begin
        stall_cnt_d    = C_STALL_MAX;
        overflow_err_d = 1'b1;
      end else begin
        stall_cnt_d = stall_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q    <= 8'd0;
      overflow_err_q <= 1'b0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      overflow_err_q <= overflow_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_demux4.sv
`default_nettype none
// ==========================================================================
// tb_bus_demux4 : vector table plus hand sequences for bus_demux4
// Revision      : 1.0
// ==========================================================================
module tb_bus_demux4;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [3:0]  full;
  logic        overflow_err;

  int n_checks = 0;
  int n_pass   = 0;

  bus_demux4 #(.WIDTH(16), .DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_sel       (in_sel),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .full         (full),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [1:0]  sel;
    logic [15:0] data;
    logic [3:0]  rdy;
    logic        exp_irdy;
    logic [3:0]  exp_ovalid;
    logic [3:0]  exp_full;
    int          chk_port;
    logic [15:0] exp_head;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic vld, input logic [1:0] sel,
                              input logic [15:0] data, input logic [3:0] rdy,
                              input logic irdy, input logic [3:0] ovalid,
                              input logic [3:0] fl, input int chk,
                              input logic [15:0] head);
    vec_t v;
    v.vld = vld; v.sel = sel; v.data = data; v.rdy = rdy;
    v.exp_irdy = irdy; v.exp_ovalid = ovalid; v.exp_full = fl;
    v.chk_port = chk; v.exp_head = head;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] head(input int p);
    return out_data[p*16 +: 16];
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic vld, input logic [1:0] sel,
                       input logic [15:0] data, input logic [3:0] rdy);
    @(negedge clk);
    in_valid  = vld;
    in_sel    = sel;
    in_data   = data;
    out_ready = rdy;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = 16'h0; out_ready = 4'h0;

    // Test 1: single word to C, then pop it
    vecs.push_back(mk(1, 2, 16'h1234, 4'h0, 1, 4'h0, 4'h0, -1, 16'h0));
    vecs.push_back(mk(0, 0, 16'h0000, 4'h0, 1, 4'h4, 4'h0,  2, 16'h1234));
    vecs.push_back(mk(0, 0, 16'h0000, 4'h4, 1, 4'h4, 4'h0,  2, 16'h1234));
    vecs.push_back(mk(0, 0, 16'h0000, 4'h0, 1, 4'h0, 4'h0, -1, 16'h0));
    // Test 2: fill A, B still accepts
    vecs.push_back(mk(1, 0, 16'hAAA1, 4'h0, 1, 4'h0, 4'h0, -1, 16'h0));
    vecs.push_back(mk(1, 0, 16'hAAA2, 4'h0, 1, 4'h1, 4'h0,  0, 16'hAAA1));
    vecs.push_back(mk(0, 0, 16'h0000, 4'h0, 0, 4'h1, 4'h1,  0, 16'hAAA1));
    vecs.push_back(mk(1, 1, 16'hBBB1, 4'h0, 1, 4'h1, 4'h1,  0, 16'hAAA1));
    vecs.push_back(mk(0, 1, 16'h0000, 4'h0, 1, 4'h3, 4'h1,  1, 16'hBBB1));
    // Test 3: pop of a full port does not admit a push in the same cycle
    vecs.push_back(mk(1, 0, 16'hAAA3, 4'h1, 0, 4'h3, 4'h1,  0, 16'hAAA1));
    vecs.push_back(mk(1, 0, 16'hAAA3, 4'h0, 1, 4'h3, 4'h0,  0, 16'hAAA2));
    vecs.push_back(mk(0, 0, 16'h0000, 4'h3, 0, 4'h3, 4'h1,  0, 16'hAAA2));
    vecs.push_back(mk(0, 0, 16'h0000, 4'h1, 1, 4'h1, 4'h0,  0, 16'hAAA3));
    vecs.push_back(mk(0, 0, 16'h0000, 4'h0, 1, 4'h0, 4'h0, -1, 16'h0));
    // Test 4: streaming through all ports with every consumer ready
    for (int k = 0; k < 8; k++) begin
      if (k == 0)
        vecs.push_back(mk(1, 2'(k % 4), 16'h4000 + 16'(k), 4'hF, 1, 4'h0, 4'h0, -1, 16'h0));
      else
        vecs.push_back(mk(1, 2'(k % 4), 16'h4000 + 16'(k), 4'hF, 1,
                          4'(1 << ((k - 1) % 4)), 4'h0, (k - 1) % 4, 16'h4000 + 16'(k - 1)));
    end
    vecs.push_back(mk(0, 0, 16'h0000, 4'hF, 1, 4'h8, 4'h0,  3, 16'h4007));
    vecs.push_back(mk(0, 0, 16'h0000, 4'h0, 1, 4'h0, 4'h0, -1, 16'h0));

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset out_valid", 64'(out_valid), 64'h0);
    check("reset full", 64'(full), 64'h0);
    check("reset overflow_err", 64'(overflow_err), 64'h0);
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      check($sformatf("reset in_ready sel%0d", s), 64'(in_ready), 64'h1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_sel = 2'd0;

    foreach (vecs[i]) begin
      drive(vecs[i].vld, vecs[i].sel, vecs[i].data, vecs[i].rdy);
      check($sformatf("row%0d in_ready", i), 64'(in_ready), 64'(vecs[i].exp_irdy));
      check($sformatf("row%0d out_valid", i), 64'(out_valid), 64'(vecs[i].exp_ovalid));
      check($sformatf("row%0d full", i), 64'(full), 64'(vecs[i].exp_full));
      if (vecs[i].chk_port >= 0)
        check($sformatf("row%0d head%0d", i, vecs[i].chk_port),
              64'(head(vecs[i].chk_port)), 64'(vecs[i].exp_head));
    end

    // Test 5: sustained stall on D raises the sticky overflow flag
    drive(1, 3, 16'hD001, 4'h0);
    drive(1, 3, 16'hD002, 4'h0);
    drive(1, 3, 16'hD003, 4'h0);
    check("t5 D full", 64'(full), 64'h8);
    check("t5 in_ready stalled", 64'(in_ready), 64'h0);
    repeat (255) @(posedge clk);
    @(negedge clk);
    #1;
    check("t5 overflow after 255", 64'(overflow_err), 64'h0);
    @(negedge clk);
    #1;
    check("t5 overflow after 256", 64'(overflow_err), 64'h1);
    drive(0, 3, 16'h0000, 4'h8);
    check("t5 drain head0", 64'(head(3)), 64'hD001);
    @(negedge clk);
    #1;
    check("t5 drain head1", 64'(head(3)), 64'hD002);
    drive(0, 3, 16'h0000, 4'h0);
    check("t5 drained out_valid", 64'(out_valid), 64'h0);
    check("t5 overflow sticky", 64'(overflow_err), 64'h1);

    // Test 6: asynchronous reset mid-cycle with A full and B occupied
    drive(1, 0, 16'h5A51, 4'h0);
    drive(1, 0, 16'h5A52, 4'h0);
    drive(1, 1, 16'h5B51, 4'h0);
    drive(0, 0, 16'h0000, 4'h0);
    check("t6 pre out_valid", 64'(out_valid), 64'h3);
    check("t6 pre full", 64'(full), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6 async out_valid", 64'(out_valid), 64'h0);
    check("t6 async full", 64'(full), 64'h0);
    check("t6 async overflow_err", 64'(overflow_err), 64'h0);
    check("t6 async in_ready", 64'(in_ready), 64'h1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 16'h7777, 4'h0);
    drive(0, 0, 16'h0000, 4'h0);
    check("t6 new out_valid", 64'(out_valid), 64'h1);
    check("t6 new head A", 64'(head(0)), 64'h7777);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
